data_mem_responder: RTL and testbench

- Responder end of the MEM-stage load/store interface of the 5-stage pipeline.
- Accepts one request per transaction from the pipeline's MEM stage and services it from an internal word array after a fixed, parameterised latency.
- Drives a stall signal to the hazard unit for as long as a request is outstanding.
- Replaces the single-cycle data memory, so the pipeline can be exercised against a slow memory.

---
 rtl/data_mem_responder_pkg.sv | 13 +
 rtl/dm_ram.sv | 24 ++
 rtl/data_mem_responder.sv | 130 +++++++++++++
 tb/tb_data_mem_responder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the MEM-stage data memory responder.
package data_mem_responder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } stateT;

   localparam int DEFAULT_LATENCY = 2;
   localparam int WORD_OFFSET     = 2;   // byte-to-word address shift

endpackage

// File: rtl/dm_ram.sv
// Single-port word array: synchronous write, registered read, access gated by en.
module dm_ram #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // One access per enabled edge: store the word or register the read word.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) mem[addr] <= wdata;
         else    rdata     <= mem[addr];
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the pipeline's MEM-stage load/store port with a fixed,
// parameterised latency; stalls the pipeline while a request is pending.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 32,
   parameter int LATENCY = DEFAULT_LATENCY
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [31:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              mem_busy
);

   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   stateT             state, stateNext;
   logic [3:0]        count, countNext;
   logic              accept, access;

   logic              weQ;
   logic [ADDR_W+1:0] addrQ;
   logic [DATA_W-1:0] wdataQ;

   logic              accWe;
   logic [ADDR_W+1:0] accAddr;
   logic [DATA_W-1:0] accWdata;
   logic              accAligned;
   logic              ramEn;
   logic [DATA_W-1:0] ramRdata;

   // Address bits above the array are deliberately ignored (aliasing).
   logic              unusedAddrBits;
   assign unusedAddrBits = ^req_addr[31:ADDR_W+2];

   // With LATENCY=1 the access happens on the accept edge, so it must use the
   // live request; otherwise it uses the copy latched at acceptance.
   assign accWe      = (state == IDLE) ? req_we                  : weQ;
   assign accAddr    = (state == IDLE) ? req_addr[ADDR_W+1:0]    : addrQ;
   assign accWdata   = (state == IDLE) ? req_wdata               : wdataQ;
   assign accAligned = (accAddr[WORD_OFFSET-1:0] == '0);
   // Reset on the access edge discards the access, so an aborted store never commits.
   assign ramEn      = access & accAligned & ~reset;

   dm_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) uRam (
      .clk   (clk),
      .en    (ramEn),
      .we    (accWe),
      .addr  (accAddr[ADDR_W+1:WORD_OFFSET]),
      .wdata (accWdata),
      .rdata (ramRdata)
   );

   // Control state: FSM state and remaining-cycles counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         count <= '0;
      end else begin
         state <= stateNext;
         count <= countNext;
      end
   end

   // Request capture at acceptance; later changes on req_* are ignored.
   always_ff @(posedge clk) begin
      if (accept) begin
         weQ    <= req_we;
         addrQ  <= req_addr[ADDR_W+1:0];
         wdataQ <= req_wdata;
      end
   end

   // Next-state and output decode. The counter holds the number of edges left
   // before RESP, so RESP is entered on the edge where it reaches zero.
   always_comb begin
      stateNext  = state;
      countNext  = count;
      accept     = 1'b0;
      access     = 1'b0;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = '0;
      mem_busy   = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            mem_busy  = req_valid;
            if (req_valid) begin
               accept    = 1'b1;
               countNext = LAT_M1;
               if (LATENCY == 1) begin
                  stateNext = RESP;
                  access    = 1'b1;
               end else begin
                  stateNext = WAIT;
               end
            end
         end
         WAIT: begin
            mem_busy  = 1'b1;
            countNext = count - 4'd1;
            if (count == 4'd1) begin
               stateNext = RESP;
               access    = 1'b1;
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            resp_err   = (addrQ[WORD_OFFSET-1:0] != '0);
            if (!weQ && (addrQ[WORD_OFFSET-1:0] == '0)) resp_rdata = ramRdata;
            stateNext  = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: two responders (LATENCY=2 and LATENCY=1) driven by
// directed transactions; expected responses queued at acceptance.
module tb_data_mem_responder;

   localparam int LAT [2] = '{2, 1};

   logic        clk;
   logic        reset;
   logic        reqValid   [2];
   logic        reqWe      [2];
   logic [31:0] reqAddr    [2];
   logic [31:0] reqWdata   [2];
   logic        reqReady   [2];
   logic        respValid  [2];
   logic [31:0] respRdata  [2];
   logic        respErr    [2];
   logic        memBusy    [2];

   int          cyc;
   int          nChecks;
   int          nFails;
   logic [31:0] model [2][256];

   typedef struct {
      string       tag;
      logic [31:0] rdata;
      logic        err;
      int          due;
   } expT;

   expT q0[$];
   expT q1[$];

   data_mem_responder #(.ADDR_W(8), .DATA_W(32), .LATENCY(2)) dut0 (
      .clk(clk), .reset(reset),
      .req_valid(reqValid[0]), .req_we(reqWe[0]), .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]),
      .req_ready(reqReady[0]), .resp_valid(respValid[0]), .resp_rdata(respRdata[0]),
      .resp_err(respErr[0]), .mem_busy(memBusy[0])
   );

   data_mem_responder #(.ADDR_W(8), .DATA_W(32), .LATENCY(1)) dut1 (
      .clk(clk), .reset(reset),
      .req_valid(reqValid[1]), .req_we(reqWe[1]), .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]),
      .req_ready(reqReady[1]), .resp_valid(respValid[1]), .resp_rdata(respRdata[1]),
      .resp_err(respErr[1]), .mem_busy(memBusy[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic expectEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Drive one request on responder i, record its accept edge and queue the expectation.
   task automatic issue(input int i, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit push, input string tag,
                        output int k);
      int  n;
      expT e;
      logic [7:0] idx;
      k = -1;
      n = 0;
      @(negedge clk);
      while (!reqReady[i] && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!reqReady[i]) begin
         expectEq({tag, ".readyTimeout"}, 32'(reqReady[i]), 32'd1);
         return;
      end
      reqValid[i] = 1'b1;
      reqWe[i]    = we;
      reqAddr[i]  = addr;
      reqWdata[i] = wdata;
      #1;
      expectEq({tag, ".busyReq"}, 32'(memBusy[i]), 32'd1);
      @(posedge clk);
      #1;
      k = cyc;
      reqValid[i] = 1'b0;
      reqAddr[i]  = 32'hFFFF_FFFF;
      reqWdata[i] = 32'h5555_AAAA;
      idx = addr[9:2];
      e.tag = tag;
      e.due = k + LAT[i] - 1;
      if (addr[1:0] != 2'b00) begin
         e.rdata = 32'h0;
         e.err   = 1'b1;
      end else if (we) begin
         e.rdata = 32'h0;
         e.err   = 1'b0;
         if (push) model[i][idx] = wdata;
      end else begin
         e.rdata = model[i][idx];
         e.err   = 1'b0;
      end
      if (push) begin
         if (i == 0) q0.push_back(e);
         else        q1.push_back(e);
      end
      @(negedge clk);
      expectEq({tag, ".busyAfter"}, 32'(memBusy[i]), (LAT[i] > 1) ? 32'd1 : 32'd0);
      expectEq({tag, ".readyAfter"}, 32'(reqReady[i]), 32'd0);
   endtask

   // Response monitor, LATENCY=2 instance.
   always @(negedge clk) begin
      expT e;
      if (respValid[0]) begin
         if (q0.size() == 0) expectEq("dut0.unexpectedResp", 32'd1, 32'd0);
         else begin
            e = q0.pop_front();
            expectEq({e.tag, ".rdata"}, respRdata[0], e.rdata);
            expectEq({e.tag, ".err"}, 32'(respErr[0]), 32'(e.err));
            expectEq({e.tag, ".cycle"}, 32'(cyc), 32'(e.due));
            expectEq({e.tag, ".busyInResp"}, 32'(memBusy[0]), 32'd0);
         end
      end
   end

   // Response monitor, LATENCY=1 instance.
   always @(negedge clk) begin
      expT e;
      if (respValid[1]) begin
         if (q1.size() == 0) expectEq("dut1.unexpectedResp", 32'd1, 32'd0);
         else begin
            e = q1.pop_front();
            expectEq({e.tag, ".rdata"}, respRdata[1], e.rdata);
            expectEq({e.tag, ".err"}, 32'(respErr[1]), 32'(e.err));
            expectEq({e.tag, ".cycle"}, 32'(cyc), 32'(e.due));
            expectEq({e.tag, ".busyInResp"}, 32'(memBusy[1]), 32'd0);
         end
      end
   end

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } txnT;

   initial begin
      int  k;
      int  kPrev;
      int  n;
      txnT stream [7];
      cyc     = 0;
      nChecks = 0;
      nFails  = 0;
      reset   = 1'b1;
      for (int i = 0; i < 2; i++) begin
         reqValid[i] = 1'b0;
         reqWe[i]    = 1'b0;
         reqAddr[i]  = 32'h0;
         reqWdata[i] = 32'h0;
      end
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         expectEq($sformatf("rst%0d.ready", i), 32'(reqReady[i]), 32'd1);
         expectEq($sformatf("rst%0d.respValid", i), 32'(respValid[i]), 32'd0);
         expectEq($sformatf("rst%0d.busy", i), 32'(memBusy[i]), 32'd0);
         expectEq($sformatf("rst%0d.rdata", i), respRdata[i], 32'd0);
      end

      // LATENCY=2: store then load back
      issue(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, "st10", k);
      issue(0, 1'b0, 32'h0000_0010, 32'h0,         1'b1, "ld10", k);
      // address aliasing modulo 1 KiB
      issue(0, 1'b1, 32'h0000_0004, 32'h0000_0011, 1'b1, "st04", k);
      issue(0, 1'b0, 32'h0000_0404, 32'h0,         1'b1, "ld404", k);
      // misaligned store must not touch word 4
      issue(0, 1'b1, 32'h0000_0013, 32'hCAFE_F00D, 1'b1, "stMis13", k);
      issue(0, 1'b0, 32'h0000_0010, 32'h0,         1'b1, "ld10b", k);
      // reset in the middle of a store's wait
      issue(0, 1'b1, 32'h0000_0020, 32'h1234_5678, 1'b1, "st20", k);
      issue(0, 1'b0, 32'h0000_0020, 32'h0,         1'b1, "ld20", k);
      issue(0, 1'b1, 32'h0000_0020, 32'hBAD0_BAD0, 1'b0, "st20abort", k);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      expectEq("abort.ready", 32'(reqReady[0]), 32'd1);
      expectEq("abort.respValid", 32'(respValid[0]), 32'd0);
      issue(0, 1'b0, 32'h0000_0020, 32'h0,         1'b1, "ld20after", k);

      // LATENCY=1: back-to-back stream, one transaction every two cycles
      stream[0] = '{1'b1, 32'h0000_0040, $urandom};
      stream[1] = '{1'b0, 32'h0000_0040, 32'h0};
      stream[2] = '{1'b1, 32'h0000_0044, $urandom};
      stream[3] = '{1'b0, 32'h0000_0044, 32'h0};
      stream[4] = '{1'b0, 32'h0000_0040, 32'h0};
      stream[5] = '{1'b0, 32'h0000_0041, 32'h0};
      stream[6] = '{1'b1, 32'h0000_0040, 32'hA5A5_0F0F};
      kPrev = 0;
      for (int s = 0; s < 7; s++) begin
         issue(1, stream[s].we, stream[s].addr, stream[s].wdata, 1'b1, $sformatf("l1s%0d", s), k);
         if (s > 0) expectEq($sformatf("l1s%0d.spacing", s), 32'(k - kPrev), 32'd2);
         kPrev = k;
      end
      issue(1, 1'b0, 32'h0000_0040, 32'h0, 1'b1, "l1final", k);

      n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      expectEq("drain.q0", 32'(q0.size()), 32'd0);
      expectEq("drain.q1", 32'(q1.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFails);
      $finish;
   end

endmodule
